// File: rtl/mat_mul_pkg.sv
// Shared defaults for the matrix-multiply block and its request arbiter.
// The pipeline depth is derived from the matrix dimension (adder-tree depth plus one multiply stage).
package mat_mul_pkg;

  localparam int W_IN_DEF  = 8;
  localparam int W_OUT_DEF = 32;
  localparam int N_DEF     = 8;
  localparam int NREQ_DEF  = 4;

  function automatic int mm_latency(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int id_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first requester at or after the pointer.
// The pointer moves past the winner only when the grant is actually taken.
module rr_arbiter
  import mat_mul_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic                     advance,
  output logic [NREQ-1:0]          grant,
  output logic [id_bits(NREQ)-1:0] id
);

  localparam int IDW = id_bits(NREQ);

  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr_reg) + i) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= (int'(id) == NREQ - 1) ? '0 : id + IDW'(1);
    end
  end

endmodule

// File: rtl/mat_mul_arb.sv
// Shares one external mat_mul pipeline among NREQ requesters; a tag pipeline that
// mirrors the mat_mul depth routes each result back to the requester that issued it.
module mat_mul_arb
  import mat_mul_pkg::*;
#(
  parameter int W_IN    = W_IN_DEF,
  parameter int W_OUT   = W_OUT_DEF,
  parameter int N       = N_DEF,
  parameter int NREQ    = NREQ_DEF,
  parameter int LATENCY = mm_latency(N)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*N*N*W_IN-1:0]   req_matrix_1,
  input  logic [NREQ*N*N*W_IN-1:0]   req_matrix_2,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [N*N*W_OUT-1:0]       rsp_result,
  output logic                       mm_cen,
  output logic                       mm_valid_in,
  output logic [N*N*W_IN-1:0]        mm_matrix_1,
  output logic [N*N*W_IN-1:0]        mm_matrix_2,
  input  logic                       mm_valid_out,
  input  logic [N*N*W_OUT-1:0]       mm_result,
  output logic                       err
);

  localparam int IDW = id_bits(NREQ);
  localparam int MW  = N * N * W_IN;

  logic            stall;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;

  logic [LATENCY-1:0] tag_valid_reg;
  logic [IDW-1:0]     tag_id_reg [LATENCY];
  logic               tail_valid;
  logic [IDW-1:0]     tail_id;
  logic               err_reg;

  // A result nobody will take freezes everything, including new grants.
  assign stall   = |(rsp_valid & ~rsp_ready);
  assign mm_cen  = ~stall;
  assign arb_req = (rstn && !stall) ? req_valid : '0;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (arb_req),
    .advance (mm_valid_in),
    .grant   (grant),
    .id      (grant_id)
  );

  assign req_ready   = grant;
  assign mm_valid_in = |grant;

  // AND-OR operand mux; grant is one-hot so the OR chain selects exactly one source.
  logic [MW-1:0] mux_1 [NREQ+1];
  logic [MW-1:0] mux_2 [NREQ+1];
  assign mux_1[0] = '0;
  assign mux_2[0] = '0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mux
    assign mux_1[gi+1] = mux_1[gi] | (req_matrix_1[gi*MW +: MW] & {MW{grant[gi]}});
    assign mux_2[gi+1] = mux_2[gi] | (req_matrix_2[gi*MW +: MW] & {MW{grant[gi]}});
  end

  assign mm_matrix_1 = mux_1[NREQ];
  assign mm_matrix_2 = mux_2[NREQ];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_valid_reg <= '0;
    end else if (mm_cen) begin
      tag_valid_reg[0] <= mm_valid_in;
      tag_id_reg[0]    <= grant_id;
      for (int s = 1; s < LATENCY; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
    end
  end

  assign tail_valid = tag_valid_reg[LATENCY-1];
  assign tail_id    = tag_id_reg[LATENCY-1];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
    assign rsp_valid[gi] = tail_valid && (tail_id == IDW'(gi));
  end

  assign rsp_result = mm_result;

  // Sticky: a tag/result disagreement means the mat_mul depth does not match LATENCY.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_reg <= 1'b0;
    end else if (mm_cen && (tail_valid != mm_valid_out)) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;

endmodule

// File: doc/mat_mul_arb.md
MAT_MUL_ARB -- requirements
Module: mat_mul_arb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  W_IN  8  matrix element width, signed
  W_OUT  32  result element width, signed
  N  8  matrix dimension (N x N)
  NREQ  4  number of requesters
  LATENCY  $clog2(N)+1  mat_mul pipeline depth in enabled cycles
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  clock
  rstn  in  1  synchronous reset, active low
  req_valid  in  NREQ  per-requester request valid
  req_ready  out  NREQ  per-requester request accepted this cycle
  req_matrix_1  in  NREQ x N x N x W_IN  per-requester operand A
  req_matrix_2  in  NREQ x N x N x W_IN  per-requester operand B
  rsp_valid  out  NREQ  one-hot result valid
  rsp_ready  in  NREQ  per-requester result accept
  rsp_result  out  N x N x W_OUT  result of head transaction
  mm_cen  out  1  mat_mul clock enable
  mm_valid_in  out  1  mat_mul input valid
  mm_matrix_1  out  N x N x W_IN  muxed operand A
  mm_matrix_2  out  N x N x W_IN  muxed operand B
  mm_valid_out  in  1  mat_mul output valid
  mm_result  in  N x N x W_OUT  mat_mul result
  err  out  1  sticky tag/valid mismatch flag
REQ-003 Clock is clk; reset is rstn, synchronous, active low; no other clock or reset.

Function
REQ-004 Block SHALL share one mat_mul instance among NREQ requesters with round-robin arbitration.
REQ-005 Round-robin pointer SHALL start at requester 0; search order ptr, ptr+1, ... wrapping modulo NREQ.
REQ-006 On acceptance by requester g, pointer SHALL become (g+1) mod NREQ; unchanged when nothing accepted.
REQ-007 stall = |(rsp_valid & ~rsp_ready); combinational.
REQ-008 mm_cen SHALL equal ~stall; whole pipeline freezes when stalled.
REQ-009 req_ready SHALL be one-hot grant of highest-priority valid requester when ~stall, else all zero.
REQ-010 mm_valid_in SHALL equal |req_ready; mm_matrix_1/2 SHALL be granted requester's operands, zero when no grant.
REQ-011 Tag pipeline: LATENCY stages of {valid, id[$clog2(NREQ)-1:0]}, advancing only when mm_cen=1; stage 0 loads {mm_valid_in, grant id}.
REQ-012 rsp_valid SHALL be onehot(tail id) when tail valid, else 0; rsp_result SHALL be mm_result unmodified (no width change).
REQ-013 Latency: request accepted at edge k, no stalls -> rsp_valid asserted in the cycle after edge k+LATENCY-1 (LATENCY enabled edges total); each stall cycle adds one.
REQ-014 rsp_valid and rsp_result SHALL hold stable while stalled.
REQ-015 Simultaneous rsp accept and new request in same cycle SHALL both proceed (full throughput, one op per cycle).
REQ-016 err SHALL set when tail valid differs from mm_valid_out in a cycle with mm_cen=1 and clear only on reset.
REQ-017 Requester whose req_valid drops without req_ready SHALL lose no state; nothing is recorded.

Reset
REQ-018 While rstn=0 at clk edge: all tag stages invalid, pointer 0, err 0.
REQ-019 During and after reset: req_ready=0 only while rstn=0; rsp_valid=0, mm_valid_in=0, mm_cen=1 until first grant.
REQ-020 Reset mid-operation SHALL discard in-flight transactions; no rsp_valid for them afterwards.

Structure
REQ-021 Shared package mat_mul_pkg SHALL hold W_IN, W_OUT, N defaults and LATENCY derivation function.
REQ-022 Round-robin arbiter SHALL be sub-module rr_arbiter (req, advance -> one-hot grant, id).
REQ-023 mat_mul is instantiated outside this block.

Verification
REQ-024 Single request from requester 2, rsp_ready all 1 -> req_ready=4'b0100 one cycle; rsp_valid=4'b0100 LATENCY=4 cycles later with correct product.
REQ-025 All four req_valid held 1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses in same order, one per cycle.
REQ-026 Response to requester 1 with rsp_ready[1]=0 for 3 cycles -> mm_cen=0, req_ready=0, rsp held 3 cycles; then advances.
REQ-027 Reset asserted with 3 ops in flight -> no rsp_valid after reset; next grant from requester 0.
REQ-028 Model drives mm_valid_out=0 when tag valid -> err=1 and stays 1 until rstn=0.
REQ-029 Random operands in 0..255 for 100 ops, random rsp_ready -> every result equals signed reference product, routed to correct requester.
